pad_inserter: RTL and testbench

Zero-border inserter directly upstream of the 3x3 kernel window generator. Accepts an unpadded feature map as a stream of 64-bit channel vectors (8 channels × 8 bit) in raster order, channel-group fastest. Emits the same map with a one-pixel zero border on all four sides, i.e. (W+2)×(H+2) pixels of D = in_channels/8 vectors each. The window generator therefore produces "same"-size 3x3 convolution windows.

---
 rtl/pad_pkg.sv | 25 ++
 rtl/pad_inserter_if.sv | 12 +
 rtl/stream_out_reg.sv | 27 ++
 rtl/pad_inserter.sv | 115 +++++++++++
 tb/tb_pad_inserter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_pkg.sv
// Shared types for the zero-border inserter: geometry config and control states.
// Pure declarations; no logic lives here.
package pad_pkg;

    localparam int DATA_W = 64;
    localparam int DIM_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        PAD,
        PASS
    } state_t;

    // d counts 8-channel vector groups, so it is three bits narrower than the channel field
    typedef struct packed {
        logic [DIM_W-4:0] d;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
    } cfg_t;

    function automatic logic cfg_legal(input cfg_t c);
        return (c.d != '0) && (c.w != '0) && (c.h != '0);
    endfunction

endpackage

// File: rtl/pad_inserter_if.sv
// Valid/ready vector stream carrying one 8-channel group per beat.
// The master drives data/valid; the slave drives ready.
interface pad_inserter_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_out_reg.sv
// Single-stage valid/ready output register; 1 cycle latency.
// Accepts a new beat whenever empty or draining; holds data stable while stalled.
module stream_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] load_dat,
    input  logic              load_vld,
    output logic              load_rdy,
    pad_inserter_if.master    m
);
    assign load_rdy = !m.valid || m.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m.valid <= 1'b0;
            m.data  <= '0;
        end else if (load_rdy) begin
            m.valid <= load_vld;
            if (load_vld) begin
                m.data <= load_dat;
            end
        end
    end

endmodule

// File: rtl/pad_inserter.sv
// Wraps a raster feature map with a one-pixel zero border; 1 cycle input-to-output latency.
// Input is only accepted on interior positions while the output register can take a beat.
module pad_inserter #(
    parameter int DATA_W = pad_pkg::DATA_W,
    parameter int DIM_W  = pad_pkg::DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] in_channels,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    pad_inserter_if.slave    s,
    pad_inserter_if.master   m,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);
    localparam logic [DIM_W-4:0] ONE_V = (DIM_W-3)'(1);
    localparam logic [DIM_W:0]   ONE_P = (DIM_W+1)'(1);

    pad_pkg::state_t state;
    pad_pkg::cfg_t   cfg_q, cfg_new, cfg_cur;

    logic [DIM_W-4:0] vec, vec_nxt;
    logic [DIM_W:0]   col, row, col_nxt, row_nxt, w_last, h_last;
    logic             last_vec, last_col, at_end, next_border;
    logic             last_pend, start_ok;
    logic             load_vld, load_rdy, emit;
    logic [DATA_W-1:0] load_dat;
    logic             unused_ch;

    assign unused_ch = ^in_channels[2:0];
    assign cfg_new   = '{d: in_channels[DIM_W-1:3], w: img_width, h: img_height};
    assign start_ok  = (state == pad_pkg::IDLE) && start && pad_pkg::cfg_legal(cfg_new);

    // The first border vector is emitted straight out of IDLE, so geometry must come from the live inputs there
    assign cfg_cur = (state == pad_pkg::IDLE) ? cfg_new : cfg_q;
    assign w_last  = {1'b0, cfg_cur.w} + ONE_P;
    assign h_last  = {1'b0, cfg_cur.h} + ONE_P;

    assign last_vec = (vec == cfg_cur.d - ONE_V);
    assign last_col = (col == w_last);
    assign at_end   = last_vec && last_col && (row == h_last);

    always_comb begin
        vec_nxt = vec + ONE_V;
        col_nxt = col;
        row_nxt = row;
        if (last_vec) begin
            vec_nxt = '0;
            col_nxt = last_col ? '0 : col + ONE_P;
            row_nxt = last_col ? row + ONE_P : row;
        end
    end

    assign next_border = (row_nxt == '0) || (row_nxt == h_last) ||
                         (col_nxt == '0) || (col_nxt == w_last);

    // State encodes whether the current position is border (PAD) or interior (PASS)
    assign load_vld = start_ok ||
                      ((state == pad_pkg::PAD) && !last_pend) ||
                      ((state == pad_pkg::PASS) && s.valid);
    assign load_dat = (state == pad_pkg::PASS) ? s.data : '0;
    assign emit     = load_vld && load_rdy;
    assign s.ready  = (state == pad_pkg::PASS) && load_rdy;
    assign busy     = (state != pad_pkg::IDLE);

    stream_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_dat (load_dat),
        .load_vld (load_vld),
        .load_rdy (load_rdy),
        .m        (m)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= pad_pkg::IDLE;
            cfg_q     <= '0;
            vec       <= '0;
            col       <= '0;
            row       <= '0;
            last_pend <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= (state == pad_pkg::IDLE) && start && !pad_pkg::cfg_legal(cfg_new);
            if (start_ok) begin
                cfg_q <= cfg_new;
            end
            if (emit) begin
                vec <= vec_nxt;
                col <= col_nxt;
                row <= row_nxt;
                if (at_end) begin
                    last_pend <= 1'b1;
                    state     <= pad_pkg::PAD;
                end else begin
                    state <= next_border ? pad_pkg::PAD : pad_pkg::PASS;
                end
            end else if (last_pend && m.valid && m.ready) begin
                state     <= pad_pkg::IDLE;
                last_pend <= 1'b0;
                done      <= 1'b1;
                vec       <= '0;
                col       <= '0;
                row       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pad_inserter.sv
// Directed bench for pad_inserter: hand-computed padded frames, stalls, aborts and bad configs.
module tb_pad_inserter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_channels = '0;
    logic [15:0] img_width = '0;
    logic [15:0] img_height = '0;
    logic        busy, done, cfg_err;

    always #5 clk = ~clk;

    pad_inserter_if #(.DATA_W(64)) s_if ();
    pad_inserter_if #(.DATA_W(64)) m_if ();

    pad_inserter #(.DATA_W(64), .DIM_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_channels (in_channels),
        .img_width   (img_width),
        .img_height  (img_height),
        .s           (s_if),
        .m           (m_if),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          in_cnt = 0;
    int          last_hs_cyc = 0;
    bit          in_hs = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] outq[$];
    logic [63:0] src[$];
    int          frame_id = 0;
    bit          rnd_rdy = 1'b0;
    bit          gaps = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Handshakes are sampled mid-cycle; they complete on the following rising edge
    always @(negedge clk) begin
        in_hs = (s_if.valid === 1'b1) && (s_if.ready === 1'b1);
        if (in_hs) in_cnt++;
        if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
            outq.push_back(m_if.data);
            last_hs_cyc = cyc;
        end
        if (rst_n && stall_prev) begin
            check_eq("hold_valid", 64'(m_if.valid), 64'd1);
            check_eq("hold_data", m_if.data, held);
        end
        stall_prev = rst_n && (m_if.valid === 1'b1) && (m_if.ready === 1'b0);
        held = m_if.data;
    end

    int src_idx = 0;
    int seen_id = 0;
    always @(posedge clk) begin
        #1;
        if (seen_id != frame_id) begin
            seen_id = frame_id;
            src_idx = 0;
        end else if (in_hs) begin
            src_idx++;
        end
        m_if.ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (src_idx < src.size() && (!gaps || $urandom_range(0, 1) == 1)) begin
            s_if.valid = 1'b1;
            s_if.data  = src[src_idx];
        end else begin
            s_if.valid = 1'b0;
            s_if.data  = '0;
        end
    end

    task automatic load_src(input logic [63:0] v[$]);
        src = v;
        frame_id++;
    endtask

    task automatic pulse_start(input int ch, input int w, input int h);
        @(posedge clk);
        #1;
        start       = 1'b1;
        in_channels = 16'(ch);
        img_width   = 16'(w);
        img_height  = 16'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check_eq({tag, "_busy_off"}, 64'(busy), 64'd0);
            check_eq({tag, "_done_lat"}, 64'(cyc - last_hs_cyc), 64'd1);
            @(negedge clk);
            check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [63:0] exp[$]);
        check_eq({tag, "_count"}, 64'(outq.size() - base), 64'(exp.size()));
        foreach (exp[i]) begin
            if (base + i < outq.size())
                check_eq($sformatf("%s_out%0d", tag, i), outq[base + i], exp[i]);
        end
    endtask

    logic [63:0] v1[$];
    logic [63:0] v2[$];
    logic [63:0] v3[$];
    logic [63:0] exp1[$];
    logic [63:0] exp2[$];
    logic [63:0] exp3[$];

    initial begin
        int  base;
        int  ib;
        bit  ok;
        bit  saw_done;

        v1   = '{64'd1, 64'd2, 64'd3, 64'd4};
        exp1 = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
        v2   = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
        exp2 = {};
        for (int i = 0; i < 8; i++) exp2.push_back(64'd0);
        exp2.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        exp2.push_back(64'hBBBB_BBBB_BBBB_BBBB);
        for (int i = 0; i < 8; i++) exp2.push_back(64'd0);
        v3   = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66};
        exp3 = '{0, 0, 0, 0, 0,
                 0, 64'h11, 64'h22, 64'h33, 0,
                 0, 64'h44, 64'h55, 64'h66, 0,
                 0, 0, 0, 0, 0};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_ready", 64'(s_if.ready), 64'd0);
        check_eq("rst_m_valid", 64'(m_if.valid), 64'd0);
        check_eq("rst_m_data", m_if.data, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_cfg_err", 64'(cfg_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // D=1 W=2 H=2, free-flowing
        base = outq.size();
        ib   = in_cnt;
        load_src(v1);
        pulse_start(8, 2, 2);
        check_eq("t1_first_valid", 64'(m_if.valid), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_done("t1");
        check_frame("t1", base, exp1);
        check_eq("t1_inputs", 64'(in_cnt - ib), 64'd4);

        // D=2 W=1 H=1
        base = outq.size();
        ib   = in_cnt;
        load_src(v2);
        pulse_start(16, 1, 1);
        wait_done("t2");
        check_frame("t2", base, exp2);
        check_eq("t2_inputs", 64'(in_cnt - ib), 64'd2);

        // D=1 W=3 H=2 with random back-pressure and input gaps
        rnd_rdy = 1'b1;
        gaps    = 1'b1;
        base = outq.size();
        ib   = in_cnt;
        load_src(v3);
        pulse_start(8, 3, 2);
        wait_done("t3");
        check_frame("t3", base, exp3);
        check_eq("t3_inputs", 64'(in_cnt - ib), 64'd6);
        rnd_rdy = 1'b0;
        gaps    = 1'b0;

        // abort mid-frame with reset, then a clean frame
        base = outq.size();
        load_src(v1);
        pulse_start(8, 2, 2);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (outq.size() - base >= 5) ok = 1'b1;
        end
        check_eq("t4_reach5", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t4_rst_valid", 64'(m_if.valid), 64'd0);
        check_eq("t4_rst_busy", 64'(busy), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_eq("t4_no_done", 64'(saw_done), 64'd0);
        base = outq.size();
        ib   = in_cnt;
        load_src(v1);
        pulse_start(8, 2, 2);
        wait_done("t4");
        check_frame("t4", base, exp1);
        check_eq("t4_inputs", 64'(in_cnt - ib), 64'd4);

        // illegal configs: D=0, then H=0
        base = outq.size();
        pulse_start(4, 2, 2);
        check_eq("t5a_cfg_err", 64'(cfg_err), 64'd1);
        check_eq("t5a_busy", 64'(busy), 64'd0);
        check_eq("t5a_valid", 64'(m_if.valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("t5a_err_pulse", 64'(cfg_err), 64'd0);
        check_eq("t5a_valid2", 64'(m_if.valid), 64'd0);
        pulse_start(8, 2, 0);
        check_eq("t5b_cfg_err", 64'(cfg_err), 64'd1);
        check_eq("t5b_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_no_out", 64'(outq.size() - base), 64'd0);
        check_eq("t5_valid", 64'(m_if.valid), 64'd0);

        // start while busy is ignored
        base = outq.size();
        ib   = in_cnt;
        load_src(v1);
        pulse_start(8, 2, 2);
        repeat (3) @(posedge clk);
        #1;
        start       = 1'b1;
        in_channels = 16'd16;
        img_width   = 16'd5;
        img_height  = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("t6_no_err", 64'(cfg_err), 64'd0);
        wait_done("t6");
        check_frame("t6", base, exp1);
        check_eq("t6_inputs", 64'(in_cnt - ib), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
